// File: rtl/iso14443a_pkg.sv
// ISO14443A_pkg
// Constants, the CRC_A byte-update function and the FSM encoding shared by the
// ISO/IEC 14443-A receive and transmit paths.
//   CRC_A_INIT           : CRC_A preset value (0x6363)
//   CRC_A_POLY_REFLECTED : CRC_A polynomial, bit-reversed form (0x8408)
//   crc_a_update_byte()  : next CRC after shifting in one byte, LSB first
//   RxFrameBufState      : rx_frame_buffer FSM states
package ISO14443A_pkg;

   localparam logic [15:0] CRC_A_INIT           = 16'h6363;
   localparam logic [15:0] CRC_A_POLY_REFLECTED = 16'h8408;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RECEIVING = 2'd1,
      DONE      = 2'd2
   } RxFrameBufState;

   // Bit-serial reflected CRC, unrolled over the eight bits of one byte.
   // The byte goes in LSB first, the same order it travels on the air.
   function automatic logic [15:0] crc_a_update_byte(input logic [15:0] crc,
                                                     input logic [7:0]  data_byte);
      logic [15:0] c;
      c = crc ^ {8'h00, data_byte};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_A_POLY_REFLECTED) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc_a_byte.sv
// crc_a_byte
// Combinational one-byte CRC_A step, shared by the rx and tx paths.
//   crc_in  : current CRC register value
//   data    : byte to absorb (LSB is the first bit on the air)
//   crc_out : CRC after absorbing data
module crc_a_byte (
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);
   import ISO14443A_pkg::*;

   assign crc_out = crc_a_update_byte(crc_in, data);

endmodule

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer
// Captures one PCD frame from the rx byte decoder into a byte buffer, runs
// CRC_A over it on the fly and publishes a one-cycle summary at end of frame.
//   clk, rst        : clock, asynchronous active-high reset
//   soc / eoc       : rx start / end of frame pulses
//   data, data_bits : rx byte (LSB first) and, at eoc, partial-byte bit count
//   data_valid      : rx full-byte strobe
//   sequence_error,
//   parity_error    : rx error pulses
//   rd_addr/rd_data : registered read port into the buffer (1-cycle latency)
//   frame_valid     : one-cycle pulse, summary outputs below just updated
//   byte_count, last_bits, crc_ok, rx_error, overflow : frame summary
//   busy            : frame in progress
module rx_frame_buffer #(
   parameter int MAX_BYTES = 16,
   parameter int ADDR_W    = $clog2(MAX_BYTES),
   parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soc,
   input  logic              eoc,
   input  logic [7:0]        data,
   input  logic [2:0]        data_bits,
   input  logic              data_valid,
   input  logic              sequence_error,
   input  logic              parity_error,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              frame_valid,
   output logic [CNT_W-1:0]  byte_count,
   output logic [2:0]        last_bits,
   output logic              crc_ok,
   output logic              rx_error,
   output logic              overflow,
   output logic              busy
);
   import ISO14443A_pkg::*;

   localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_BYTES);
   localparam logic [ADDR_W:0]  MAX_RD     = (ADDR_W + 1)'(MAX_BYTES);

   RxFrameBufState    state_q, state_nxt;
   logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_nxt;
   logic [15:0]       crc_q, crc_nxt, crc_upd;
   logic              err_q, err_nxt;
   logic              ovf_q, ovf_nxt;
   logic [2:0]        last_bits_nxt;
   logic              summary_load;
   logic              crc_ok_nxt;

   logic              room;
   logic              partial;
   logic [7:0]        partial_mask;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_byte;
   logic [7:0]        frame_mem [MAX_BYTES];

   crc_a_byte u_crc (
      .crc_in  (crc_q),
      .data    (data),
      .crc_out (crc_upd)
   );

   assign room         = (wr_ptr_q < MAX_CNT);
   assign partial      = eoc && (data_bits != 3'd0);
   assign partial_mask = (8'h01 << data_bits) - 8'h01;
   assign busy         = (state_q == RECEIVING);

   // The *_nxt values are the frame state after this cycle's inputs, so a byte
   // arriving together with eoc is already counted and CRC'd in the summary.
   // NOTE: every signal driven here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt     = state_q;
      wr_ptr_nxt    = wr_ptr_q;
      crc_nxt       = crc_q;
      err_nxt       = err_q;
      ovf_nxt       = ovf_q;
      last_bits_nxt = 3'd0;
      summary_load  = 1'b0;
      wr_en         = 1'b0;
      wr_addr       = wr_ptr_q[ADDR_W-1:0];
      wr_byte       = data;

      if (soc) begin
         // A new frame always wins, even mid-frame or in DONE.
         state_nxt  = RECEIVING;
         wr_ptr_nxt = '0;
         crc_nxt    = CRC_A_INIT;
         err_nxt    = 1'b0;
         ovf_nxt    = 1'b0;
      end else begin
         case (state_q)
            RECEIVING: begin
               // Once an error is latched the rest of the frame is junk.
               if (data_valid && !err_q && !partial) begin
                  if (room) begin
                     wr_en      = 1'b1;
                     wr_ptr_nxt = wr_ptr_q + CNT_W'(1);
                     crc_nxt    = crc_upd;
                  end else begin
                     ovf_nxt = 1'b1;
                  end
               end
               if (sequence_error || parity_error) begin
                  err_nxt = 1'b1;
               end
               if (eoc) begin
                  state_nxt    = DONE;
                  summary_load = 1'b1;
                  // Partial trailing byte: stored for inspection, but kept out
                  // of byte_count and the CRC.
                  if (partial && !err_nxt) begin
                     last_bits_nxt = data_bits;
                     wr_en         = room;
                     wr_byte       = data & partial_mask;
                  end
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign crc_ok_nxt = (crc_nxt == 16'h0000) && (last_bits_nxt == 3'd0) &&
                       (wr_ptr_nxt >= CNT_W'(3)) && !err_nxt && !ovf_nxt;

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         crc_q       <= CRC_A_INIT;
         err_q       <= 1'b0;
         ovf_q       <= 1'b0;
         frame_valid <= 1'b0;
         byte_count  <= '0;
         last_bits   <= 3'd0;
         crc_ok      <= 1'b0;
         rx_error    <= 1'b0;
         overflow    <= 1'b0;
         rd_data     <= 8'h00;
      end else begin
         state_q     <= state_nxt;
         wr_ptr_q    <= wr_ptr_nxt;
         crc_q       <= crc_nxt;
         err_q       <= err_nxt;
         ovf_q       <= ovf_nxt;
         frame_valid <= summary_load;
         if (summary_load) begin
            byte_count <= wr_ptr_nxt;
            last_bits  <= last_bits_nxt;
            crc_ok     <= crc_ok_nxt;
            rx_error   <= err_nxt;
            overflow   <= ovf_nxt;
         end
         rd_data <= ({1'b0, rd_addr} < MAX_RD) ? frame_mem[rd_addr] : 8'h00;
      end
   end

   // NOTE: the byte array has no reset; its contents only matter below
   // byte_count, which is always freshly written, and a reset port would turn
   // the array into a large bank of resettable flops.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         frame_mem[wr_addr] <= wr_byte;
      end
   end

endmodule

// File: tb/tb_rx_frame_buffer.sv
module tb_rx_frame_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       soc = 1'b0, eoc = 1'b0, data_valid = 1'b0;
   logic       sequence_error = 1'b0, parity_error = 1'b0;
   logic [7:0] data = 8'h00;
   logic [2:0] data_bits = 3'd0;
   logic [3:0] rd_addr = 4'd0;

   // 16-byte instance
   logic [7:0] rd_data16;
   logic       fv16, ok16, er16, ov16, busy16;
   logic [4:0] bc16;
   logic [2:0] lb16;
   // 4-byte instance (overflow behaviour)
   logic [7:0] rd_data4;
   logic       fv4, ok4, er4, ov4, busy4;
   logic [2:0] bc4;
   logic [2:0] lb4;

   int total = 0;
   int bad   = 0;
   int fv_cnt16 = 0;
   int fv_cnt4  = 0;

   // Frame description consumed by send_frame and the reference model.
   logic [7:0] fq[$];
   int         err_at;     // -1: none; i<size: error before byte i; size: with eoc
   int         pbits;
   logic [7:0] pdata;
   bit         join_last;  // last full byte arrives together with eoc
   bit         use_seq;

   rx_frame_buffer #(.MAX_BYTES(16)) dut (
      .clk(clk), .rst(rst), .soc(soc), .eoc(eoc), .data(data), .data_bits(data_bits),
      .data_valid(data_valid), .sequence_error(sequence_error), .parity_error(parity_error),
      .rd_addr(rd_addr), .rd_data(rd_data16), .frame_valid(fv16), .byte_count(bc16),
      .last_bits(lb16), .crc_ok(ok16), .rx_error(er16), .overflow(ov16), .busy(busy16)
   );

   rx_frame_buffer #(.MAX_BYTES(4)) dut4 (
      .clk(clk), .rst(rst), .soc(soc), .eoc(eoc), .data(data), .data_bits(data_bits),
      .data_valid(data_valid), .sequence_error(sequence_error), .parity_error(parity_error),
      .rd_addr(rd_addr[1:0]), .rd_data(rd_data4), .frame_valid(fv4), .byte_count(bc4),
      .last_bits(lb4), .crc_ok(ok4), .rx_error(er4), .overflow(ov4), .busy(busy4)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fv16 === 1'b1) fv_cnt16++;
      if (fv4 === 1'b1)  fv_cnt4++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   // CRC_A as in the ISO/IEC 14443-3 reference C code (table-free byte form).
   function automatic logic [15:0] ref_crc(input int n);
      logic [15:0] crc;
      logic [7:0]  ch;
      crc = 16'h6363;
      for (int i = 0; i < n; i++) begin
         ch  = fq[i] ^ crc[7:0];
         ch  = ch ^ (ch << 4);
         crc = (crc >> 8) ^ ({8'h00, ch} << 8) ^ ({8'h00, ch} << 3) ^ ({8'h00, ch} >> 4);
      end
      return crc;
   endfunction

   function automatic int n_accepted();
      return (err_at >= 0 && err_at < fq.size()) ? err_at : fq.size();
   endfunction

   function automatic logic [13:0] model_summary(input int max);
      int         acc, st;
      bit         ovf, e, ok;
      logic [2:0] lb;
      acc = n_accepted();
      st  = (acc > max) ? max : acc;
      ovf = acc > max;
      e   = err_at >= 0;
      lb  = e ? 3'd0 : 3'(pbits);
      ok  = (ref_crc(st) == 16'h0000) && lb == 3'd0 && st >= 3 && !e && !ovf;
      return {8'(st), lb, ok, e, ovf};
   endfunction

   function automatic logic [7:0] model_byte(input int max, input int a, output bit known);
      int         acc, st;
      logic [7:0] m;
      acc   = n_accepted();
      st    = (acc > max) ? max : acc;
      known = 1'b0;
      m     = (8'h01 << pbits) - 8'h01;
      if (a < st) begin
         known = 1'b1;
         return fq[a];
      end
      if (err_at < 0 && pbits != 0 && a == st && st < max) begin
         known = 1'b1;
         return pdata & m;
      end
      return 8'h00;
   endfunction

   function automatic logic [13:0] got16();
      return {3'b000, bc16, lb16, ok16, er16, ov16};
   endfunction

   function automatic logic [13:0] got4();
      return {5'b00000, bc4, lb4, ok4, er4, ov4};
   endfunction

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic new_frame();
      fq.delete();
      err_at    = -1;
      pbits     = 0;
      pdata     = 8'h00;
      join_last = 1'b0;
      use_seq   = 1'b0;
   endtask

   task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
      fq.push_back(b0); fq.push_back(b1); fq.push_back(b2); fq.push_back(b3);
   endtask

   task automatic send_frame();
      soc = 1'b1;
      tick();
      soc = 1'b0;
      for (int i = 0; i < fq.size(); i++) begin
         if (err_at == i) begin
            if (use_seq) sequence_error = 1'b1; else parity_error = 1'b1;
            tick();
            sequence_error = 1'b0;
            parity_error   = 1'b0;
         end
         if (!(join_last && i == fq.size() - 1)) begin
            data_valid = 1'b1;
            data       = fq[i];
            tick();
            data_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
         end
      end
      eoc       = 1'b1;
      data_bits = 3'(pbits);
      if (join_last) begin
         data_valid = 1'b1;
         data       = fq[fq.size() - 1];
      end else begin
         data = pdata;
      end
      if (err_at == fq.size()) begin
         if (use_seq) sequence_error = 1'b1; else parity_error = 1'b1;
      end
      tick();
      eoc = 1'b0; data_valid = 1'b0; data_bits = 3'd0;
      sequence_error = 1'b0; parity_error = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [22:0] r16, r4;
      r16 = {rd_data16, fv16, bc16, lb16, ok16, er16, ov16, busy16};
      r4  = {rd_data4, fv4, 3'b000, bc4, lb4, ok4, er4, ov4, busy4};
      total++;
      if (r16 !== 23'd0) begin
         $display("FAIL reset_outputs16: got=%h want=0", r16); bad++;
      end
      total++;
      if (r4 !== 23'd0) begin
         $display("FAIL reset_outputs4: got=%h want=0", r4); bad++;
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reqa();
      int f0;
      new_frame();
      pbits = 7;
      pdata = 8'h26;
      f0 = fv_cnt16;
      send_frame();
      total++;
      if (fv16 !== 1'b1) begin
         $display("FAIL reqa_fv_timing: got=%b want=1", fv16); bad++;
      end
      rd_addr = 4'd0;
      tick();
      total++;
      if (fv16 !== 1'b0) begin
         $display("FAIL reqa_fv_width: got=%b want=0", fv16); bad++;
      end
      total++;
      if (fv_cnt16 !== f0 + 1) begin
         $display("FAIL reqa_fv_count: got=%0d want=%0d", fv_cnt16, f0 + 1); bad++;
      end
      total++;
      if (got16() !== 14'h0038) begin
         $display("FAIL reqa_summary: got=%h want=%h", got16(), 14'h0038); bad++;
      end
      total++;
      if (rd_data16 !== 8'h26) begin
         $display("FAIL reqa_rd0: got=%h want=26", rd_data16); bad++;
      end
   endtask

   task automatic test_hlta();
      new_frame();
      push_bytes(8'h50, 8'h00, 8'h57, 8'hCD);
      send_frame();
      tick();
      total++;
      if (got16() !== {8'd4, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL hlta_good: got=%h want=%h", got16(), {8'd4, 3'd0, 3'b100}); bad++;
      end
      total++;
      if (got4() !== {8'd4, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL hlta_good4: got=%h want=%h", got4(), {8'd4, 3'd0, 3'b100}); bad++;
      end
      fq[3] = 8'hCE;
      send_frame();
      tick();
      total++;
      if (got16() !== {8'd4, 3'd0, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL hlta_badcrc: got=%h want=%h", got16(), {8'd4, 6'd0}); bad++;
      end
   endtask

   task automatic test_parity();
      logic [7:0] want;
      bit         known;
      new_frame();
      fq.push_back(8'h93);
      fq.push_back(8'h20);
      err_at = 2;
      pbits  = 0;
      // error as its own pulse between the last byte and eoc
      soc = 1'b1; tick(); soc = 1'b0;
      for (int i = 0; i < 2; i++) begin
         data_valid = 1'b1; data = fq[i]; tick(); data_valid = 1'b0;
      end
      parity_error = 1'b1; tick(); parity_error = 1'b0;
      data_valid = 1'b1; data = 8'hAA; tick(); data_valid = 1'b0;  // ignored after err
      eoc = 1'b1; tick(); eoc = 1'b0;
      tick();
      total++;
      if (got16() !== {8'd2, 3'd0, 1'b0, 1'b1, 1'b0}) begin
         $display("FAIL parity_summary: got=%h want=%h", got16(), {8'd2, 3'd0, 3'b010}); bad++;
      end
      for (int a = 0; a < 2; a++) begin
         rd_addr = 4'(a);
         tick();
         want = model_byte(16, a, known);
         total++;
         if (rd_data16 !== want) begin
            $display("FAIL parity_buf[%0d]: got=%h want=%h", a, rd_data16, want); bad++;
         end
      end
   endtask

   task automatic test_overflow();
      new_frame();
      for (int i = 1; i <= 6; i++) fq.push_back(8'(i));
      send_frame();
      tick();
      total++;
      if (got4() !== {8'd4, 3'd0, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL ovf_summary4: got=%h want=%h", got4(), {8'd4, 3'd0, 3'b001}); bad++;
      end
      total++;
      if (got16() !== model_summary(16)) begin
         $display("FAIL ovf_summary16: got=%h want=%h", got16(), model_summary(16)); bad++;
      end
      for (int a = 0; a < 4; a++) begin
         rd_addr = 4'(a);
         tick();
         total++;
         if (rd_data4 !== 8'(a + 1)) begin
            $display("FAIL ovf_buf[%0d]: got=%h want=%h", a, rd_data4, 8'(a + 1)); bad++;
         end
      end
   endtask

   task automatic test_restart();
      int f0;
      f0 = fv_cnt16;
      soc = 1'b1; tick(); soc = 1'b0;
      data_valid = 1'b1; data = 8'h11; tick(); data = 8'h22; tick(); data_valid = 1'b0;
      total++;
      if (busy16 !== 1'b1) begin
         $display("FAIL restart_busy: got=%b want=1", busy16); bad++;
      end
      new_frame();
      push_bytes(8'h50, 8'h00, 8'h57, 8'hCD);
      send_frame();
      tick();
      total++;
      if (fv_cnt16 !== f0 + 1) begin
         $display("FAIL restart_fv_count: got=%0d want=%0d", fv_cnt16, f0 + 1); bad++;
      end
      total++;
      if (got16() !== {8'd4, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL restart_summary: got=%h want=%h", got16(), {8'd4, 3'd0, 3'b100}); bad++;
      end
   endtask

   task automatic test_reset_mid_frame();
      int f0;
      soc = 1'b1; tick(); soc = 1'b0;
      data_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data = 8'(8'hA0 + i);
         tick();
      end
      data_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({busy16, fv16, bc16, ok16, busy4, bc4} !== 12'd0) begin
         $display("FAIL midreset_outputs: got=%h want=0", {busy16, fv16, bc16, ok16, busy4, bc4});
         bad++;
      end
      tick();
      rst = 1'b0;
      eoc = 1'b1; tick(); eoc = 1'b0;  // stray eoc of the aborted frame
      f0 = fv_cnt16;
      new_frame();
      push_bytes(8'h50, 8'h00, 8'h57, 8'hCD);
      send_frame();
      tick();
      total++;
      if (fv_cnt16 !== f0 + 1) begin
         $display("FAIL midreset_fv_count: got=%0d want=%0d", fv_cnt16, f0 + 1); bad++;
      end
      total++;
      if (got16() !== {8'd4, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL midreset_summary: got=%h want=%h", got16(), {8'd4, 3'd0, 3'b100}); bad++;
      end
   endtask

   task automatic test_random_frames();
      int          f16, f4, p;
      logic [15:0] c;
      logic [7:0]  want;
      bit          known;
      for (int n = 0; n < 40; n++) begin
         new_frame();
         p = $urandom_range(0, 18);
         for (int i = 0; i < p; i++) fq.push_back(8'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            c = ref_crc(fq.size());
            fq.push_back(c[7:0]);
            fq.push_back(c[15:8]);
         end
         case ($urandom_range(0, 5))
            0: err_at = $urandom_range(0, fq.size());
            1: begin pbits = $urandom_range(1, 7); pdata = 8'($urandom); end
            2: begin
               pbits  = $urandom_range(1, 7); pdata = 8'($urandom);
               err_at = fq.size();
            end
            default: ;
         endcase
         if (pbits == 0 && fq.size() > 0) join_last = 1'($urandom_range(0, 1));
         use_seq = 1'($urandom_range(0, 1));
         f16 = fv_cnt16;
         f4  = fv_cnt4;
         send_frame();
         tick();
         total++;
         if (fv_cnt16 !== f16 + 1 || fv_cnt4 !== f4 + 1) begin
            $display("FAIL rand%0d_fv_count: got=%0d/%0d want=%0d/%0d",
                     n, fv_cnt16, fv_cnt4, f16 + 1, f4 + 1); bad++;
         end
         total++;
         if (got16() !== model_summary(16)) begin
            $display("FAIL rand%0d_summary16: got=%h want=%h", n, got16(), model_summary(16)); bad++;
         end
         total++;
         if (got4() !== model_summary(4)) begin
            $display("FAIL rand%0d_summary4: got=%h want=%h", n, got4(), model_summary(4)); bad++;
         end
         for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            want = model_byte(16, a, known);
            if (known) begin
               total++;
               if (rd_data16 !== want) begin
                  $display("FAIL rand%0d_buf16[%0d]: got=%h want=%h", n, a, rd_data16, want); bad++;
               end
            end
            if (a < 4) begin
               want = model_byte(4, a, known);
               if (known) begin
                  total++;
                  if (rd_data4 !== want) begin
                     $display("FAIL rand%0d_buf4[%0d]: got=%h want=%h", n, a, rd_data4, want); bad++;
                  end
               end
            end
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_reqa();
      test_hlta();
      test_parity();
      test_overflow();
      test_restart();
      test_reset_mid_frame();
      test_random_frames();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
